// File: rtl/axi_mem_pkg.sv
// Shared types and helpers for the AXI memory bridge RAM.
package axi_mem_pkg;

    typedef enum logic {
        INIT  = 1'b0,
        READY = 1'b1
    } ram_state_t;

    function automatic int unsigned byte_ofs(int unsigned data_width);
        return $clog2(data_width / 8);
    endfunction

    // Even parity: the stored bit makes data plus parity carry an even number of ones.
    function automatic logic byte_parity(logic [7:0] b);
        return ^b;
    endfunction

endpackage

// File: rtl/axi_mem_ram_if.sv
// mem_* access port between the AXI slave memory bridge (master) and the RAM (slave).
interface axi_mem_ram_if #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32
);
    logic                    mem_read;
    logic                    mem_write;
    logic [ADDR_WIDTH-1:0]   mem_address;
    logic [DATA_WIDTH-1:0]   mem_write_data;
    logic [DATA_WIDTH/8-1:0] mem_write_strb;
    logic [DATA_WIDTH-1:0]   mem_read_data;
    logic                    init_done;
    logic                    parity_err;

    modport master (
        output mem_read, mem_write, mem_address, mem_write_data, mem_write_strb,
        input  mem_read_data, init_done, parity_err
    );

    modport slave (
        input  mem_read, mem_write, mem_address, mem_write_data, mem_write_strb,
        output mem_read_data, init_done, parity_err
    );
endinterface

// File: rtl/axi_mem_ram.sv
// Byte-strobed single-port RAM with post-reset clear sweep and 1-cycle read latency.
// Optional per-byte even parity when AXI_MEM_RAM_PARITY_EN is defined.
module axi_mem_ram
    import axi_mem_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32,
    parameter int DEPTH_LOG2 = 10
) (
    input logic          s_axi_aclk,
    input logic          s_axi_areset,
    axi_mem_ram_if.slave bus
);
    localparam int unsigned OFS   = byte_ofs(DATA_WIDTH);
    localparam int unsigned NB    = DATA_WIDTH / 8;
    localparam int unsigned DEPTH = 1 << DEPTH_LOG2;

    ram_state_t            state, state_nxt;
    logic [DEPTH_LOG2-1:0] cnt, cnt_nxt;

    logic                  wr_en;
    logic                  rd_en;
    logic [DEPTH_LOG2-1:0] wr_idx;
    logic [DEPTH_LOG2-1:0] rd_idx;
    logic [DATA_WIDTH-1:0] wr_data;
    logic [NB-1:0]         wr_strb;
    logic [DATA_WIDTH-1:0] rdata;

    logic [DATA_WIDTH-1:0] ram [DEPTH];

    always_ff @(posedge s_axi_aclk) begin
        if (s_axi_areset) begin
            state <= INIT;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        if (state == INIT) begin
            cnt_nxt = cnt + 1'b1;
            if (cnt == '1)
                state_nxt = READY;
        end
    end

    // INIT hijacks the write port with a full-strobe zero write at the sweep counter.
    always_comb begin
        rd_idx = bus.mem_address[DEPTH_LOG2+OFS-1:OFS];
        if (state == INIT) begin
            wr_en   = !s_axi_areset;
            wr_idx  = cnt;
            wr_data = '0;
            wr_strb = '1;
            rd_en   = 1'b0;
        end else begin
            wr_en   = !s_axi_areset && bus.mem_write;
            wr_idx  = rd_idx;
            wr_data = bus.mem_write_data;
            wr_strb = bus.mem_write_strb;
            rd_en   = bus.mem_read;
        end
    end

    always_ff @(posedge s_axi_aclk) begin
        if (wr_en) begin
            for (int unsigned i = 0; i < NB; i++) begin
                if (wr_strb[i])
                    ram[wr_idx][i*8 +: 8] <= wr_data[i*8 +: 8];
            end
        end
    end

    always_ff @(posedge s_axi_aclk) begin
        if (s_axi_areset)
            rdata <= '0;
        else if (rd_en)
            rdata <= ram[rd_idx];
    end

    assign bus.mem_read_data = rdata;
    assign bus.init_done     = (state == READY);

`ifdef AXI_MEM_RAM_PARITY_EN
    logic [NB-1:0] par [DEPTH];
    logic          perr;

    always_ff @(posedge s_axi_aclk) begin
        if (wr_en) begin
            for (int unsigned i = 0; i < NB; i++) begin
                if (wr_strb[i])
                    par[wr_idx][i] <= byte_parity(wr_data[i*8 +: 8]);
            end
        end
    end

    always_ff @(posedge s_axi_aclk) begin
        if (s_axi_areset) begin
            perr <= 1'b0;
        end else begin
            perr <= 1'b0;
            if (rd_en) begin
                for (int unsigned i = 0; i < NB; i++) begin
                    if (par[rd_idx][i] != byte_parity(ram[rd_idx][i*8 +: 8]))
                        perr <= 1'b1;
                end
            end
        end
    end

    assign bus.parity_err = perr;
`else
    assign bus.parity_err = 1'b0;
`endif

endmodule
